// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings,
// enable/disable levels, default reset PC and the prefetch entry layout.
package fetch_unit_pkg;

    localparam logic [1:0] FETCH_RUN   = 2'd0;
    localparam logic [1:0] FETCH_DRAIN = 2'd1;
    localparam logic [1:0] FETCH_HALT  = 2'd2;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, ir} entries; flush empties it in one
// cycle and the head is presented straight from the storage registers.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Storage is cleared on reset so ir/ir_pc read as zero before any fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/response accounting, redirect/halt FSM
// and prefetch FIFO. Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    output logic        misalign_fault
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             fault_q, fault_d;

    logic             active, issue, resp, misalign;
    logic             fifo_push, fifo_pop, fifo_flush;
    logic [CNT_W-1:0] fifo_cnt;
    logic [31:0]      redir_pc;
    fetch_entry_t     entry_in, head;

`ifdef FETCH_MISALIGN_CHK_EN
    always_comb misalign = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    always_comb misalign = 1'b0;
`endif

    always_comb begin
        active   = (state_q == FETCH_RUN) || (state_q == FETCH_DRAIN);
        imem_req = rst_n && active && !redirect_valid
                   && ((32'(outst_q) + 32'(fifo_cnt)) < FIFO_DEPTH)
                   && (32'(outst_q) < MAX_OUTST);
        issue    = imem_req && imem_gnt;
        resp     = imem_rvalid && (outst_q != '0);
        redir_pc = {redirect_pc[31:2], 2'b00};
        fifo_pop = ir_valid && ir_ready;

        outst_d = outst_q;
        if (issue && !resp) begin
            outst_d = outst_q + 1'b1;
        end else if (!issue && resp) begin
            outst_d = outst_q - 1'b1;
        end

        pc_d        = pc_q;
        resp_pc_d   = resp_pc_q;
        state_d     = state_q;
        drop_d      = drop_q;
        fault_d     = fault_q;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        entry_in.pc = resp_pc_q;
        entry_in.ir = imem_rdata;

        if (active) begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            // Responses are in order: stale ones come first and are counted off by drop.
            if (resp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            if ((state_q == FETCH_DRAIN) && (drop_d == '0)) begin
                state_d = FETCH_RUN;
            end
            if (halt) begin
                fifo_flush = 1'b1;
                fifo_push  = 1'b0;
                state_d    = FETCH_HALT;
            end else if (redirect_valid) begin
                fifo_flush = 1'b1;
                fifo_push  = 1'b0;
                if (misalign) begin
                    fault_d = ENABLE;
                    state_d = FETCH_HALT;
                end else begin
                    pc_d      = redir_pc;
                    resp_pc_d = redir_pc;
                    drop_d    = outst_d;
                    state_d   = (outst_d != '0) ? FETCH_DRAIN : FETCH_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH_RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
            fault_q   <= DISABLE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            fault_q   <= fault_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (entry_in),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head),
        .count     (fifo_cnt)
    );

    always_comb begin
        imem_addr      = pc_q;
        ir_valid       = (fifo_cnt != '0);
        ir             = head.ir;
        ir_pc          = head.pc;
        misalign_fault = fault_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model with a per-cycle compare,
// an in-order imem responder with programmable latency, and directed scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAXO     = 2;
    localparam logic [31:0] SALT     = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        misalign_fault;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH),
        .MAX_OUTST  (MAXO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int unsigned age;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } word_t;

    req_t        pend[$];
    word_t       expq[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_fault;
    bit          rst_prev;
    int          checks = 0;
    int          errors = 0;
    int unsigned lat = 1;
    bit          force_rv = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ SALT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic squash_all();
        foreach (pend[i]) pend[i].stale = 1'b1;
        expq.delete();
    endtask

    // One cycle of the reference model: compare, then advance to the next edge.
    task automatic model_cycle();
        bit          exp_req;
        bit          exp_v;
        int unsigned occ;
        req_t        r;
        word_t       w;
        occ     = pend.size() + expq.size();
        exp_req = !m_halted && !redirect_valid && (occ < DEPTH) && (pend.size() < MAXO);
        exp_v   = (expq.size() != 0);
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("ir_valid", ir_valid, exp_v);
        if (exp_v) begin
            check("ir", ir, expq[0].ir);
            check("ir_pc", ir_pc, expq[0].pc);
        end
        check("misalign_fault", misalign_fault, m_fault);

        foreach (pend[i]) pend[i].age++;
        if (exp_v && ir_ready) void'(expq.pop_front());
        if (imem_rvalid && pend.size() > 0) begin
            r = pend.pop_front();
            if (!r.stale && !m_halted) begin
                w.pc = r.addr;
                w.ir = word_at(r.addr);
                expq.push_back(w);
            end
        end
        if (exp_req && imem_gnt) begin
            r.addr  = m_pc;
            r.stale = 1'b0;
            r.age   = 0;
            pend.push_back(r);
            m_pc = m_pc + 32'd4;
        end
        if (!m_halted) begin
            if (halt) begin
                squash_all();
                m_halted = 1'b1;
            end else if (redirect_valid) begin
                squash_all();
`ifdef FETCH_MISALIGN_CHK_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    m_fault  = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_pc = {redirect_pc[31:2], 2'b00};
                end
`else
                m_pc = {redirect_pc[31:2], 2'b00};
`endif
            end
        end
    endtask

    // Compare process: samples 3 time units after the falling edge.
    initial begin
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                check("reset_req", imem_req, 1'b0);
                if (rst_prev) begin
                    check("reset_ir_valid", ir_valid, 1'b0);
                    check("reset_ir", ir, 32'h0);
                    check("reset_ir_pc", ir_pc, 32'h0);
                    check("reset_fault", misalign_fault, 1'b0);
                end
                pend.delete();
                expq.delete();
                m_pc     = RESET_PC;
                m_halted = 1'b0;
                m_fault  = 1'b0;
                rst_prev = 1'b1;
            end else begin
                rst_prev = 1'b0;
                model_cycle();
            end
        end
    end

    // In-order imem responder: answers the oldest request once it is lat cycles old.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (force_rv) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (pend.size() > 0 && (pend[0].age + 1) >= lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_at(pend[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_consume(output logic [31:0] pc, output logic [31:0] word, output int waited);
        bit got;
        got    = 1'b0;
        pc     = '0;
        word   = '0;
        waited = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #4;
            waited = i + 1;
            if (ir_valid && ir_ready) begin
                pc   = ir_pc;
                word = ir;
                got  = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL consume_timeout: got no handshake want one within 60 cycles at %0t", $time);
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    logic [31:0] cpc;
    logic [31:0] cword;
    int          waited;
    bit          found;

    initial begin
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        ir_ready       = 1'b1;
        tick(3);

        // Stray response with nothing outstanding must be ignored.
        rst_n    = 1'b1;
        force_rv = 1'b1;
        tick(1);
        force_rv = 1'b0;
        imem_gnt = 1'b1;

        // Streaming from reset.
        wait_consume(cpc, cword, waited);
        check("first_pc", cpc, 32'h0000_0000);
        check("first_ir", cword, 32'hC0DE_0000);
        wait_consume(cpc, cword, waited);
        check("second_pc", cpc, 32'h0000_0004);
        check("second_gap", waited, 1);
        wait_consume(cpc, cword, waited);
        check("third_pc", cpc, 32'h0000_0008);
        check("third_ir", cword, 32'hC0DE_0008);
        tick(10);

        // Decoder stall fills the FIFO exactly.
        ir_ready = 1'b0;
        tick(10);
        #4;
        check("stall_model_depth", expq.size(), DEPTH);
        check("stall_req", imem_req, 1'b0);
        check("stall_valid", ir_valid, 1'b1);
        @(negedge clk);
        ir_ready = 1'b1;
        tick(8);

        // Redirect with two requests outstanding.
        lat = 3;
        tick(6);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pend.size() == 2) found = 1'b1;
        end
        check("two_outstanding_seen", found, 1'b1);
        pulse_redirect(32'h0000_0100);
        wait_consume(cpc, cword, waited);
        check("redir_pc", cpc, 32'h0000_0100);
        check("redir_ir", cword, 32'hC0DE_0100);
        lat = 1;
        tick(6);

        // Redirect coinciding with a response and a decoder handshake.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pend.size() > 0 && expq.size() > 0) found = 1'b1;
        end
        check("coincide_setup_seen", found, 1'b1);
        pulse_redirect(32'h0000_0200);
        #4;
        check("valid_after_redirect", ir_valid, 1'b0);
        wait_consume(cpc, cword, waited);
        check("redir2_pc", cpc, 32'h0000_0200);
        tick(4);

        // PC wrap at the top of the address space.
        @(negedge clk);
        pulse_redirect(32'hFFFF_FFF8);
        wait_consume(cpc, cword, waited);
        check("wrap_pc0", cpc, 32'hFFFF_FFF8);
        wait_consume(cpc, cword, waited);
        check("wrap_pc1", cpc, 32'hFFFF_FFFC);
        wait_consume(cpc, cword, waited);
        check("wrap_pc2", cpc, 32'h0000_0000);
        check("wrap_ir2", cword, 32'hC0DE_0000);
        tick(4);

`ifdef FETCH_MISALIGN_CHK_EN
        @(negedge clk);
        pulse_redirect(32'h0000_0102);
        #4;
        check("misalign_fault_set", misalign_fault, 1'b1);
        check("misalign_req", imem_req, 1'b0);
        check("misalign_valid", ir_valid, 1'b0);
        tick(4);
        #4;
        check("misalign_sticky", misalign_fault, 1'b1);
        do_reset();
`else
        @(negedge clk);
        pulse_redirect(32'h0000_0302);
        wait_consume(cpc, cword, waited);
        check("lsbs_ignored_pc", cpc, 32'h0000_0300);
        check("lsbs_ignored_fault", misalign_fault, 1'b0);
`endif
        tick(4);

        // Halt, then a redirect that must be ignored until reset.
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        #4;
        check("halt_req", imem_req, 1'b0);
        check("halt_valid", ir_valid, 1'b0);
        @(negedge clk);
        pulse_redirect(32'h0000_0400);
        tick(3);
        #4;
        check("halt_redir_req", imem_req, 1'b0);
        check("halt_redir_valid", ir_valid, 1'b0);
        do_reset();
        wait_consume(cpc, cword, waited);
        check("post_reset_pc", cpc, RESET_PC);
        check("post_reset_ir", cword, 32'hC0DE_0000);
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
